// File: rtl/conv_decoder_pkg.sv
// Shared types for the decoder pixel link: pixel width, signed pixel type and feeder FSM states.
package conv_decoder_pkg;
  localparam int PIX_W = 18;
  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} feeder_state_t;
endpackage

// File: rtl/conv_decoder_pixel_feeder_if.sv
// Decoder pixel link between the feeder (master) and the decoder input buffer (slave).
interface conv_decoder_pixel_feeder_if;
  import conv_decoder_pkg::*;
  // start is a one-cycle strobe qualifying input_pixel; there is no backpressure.
  // dec_ready is a status flag from the decoder, expected high on the cycle after each start.
  logic   start;
  pixel_t input_pixel;
  logic   dec_ready;
  modport master (output start, output input_pixel, input dec_ready);
  modport slave  (input start, input input_pixel, output dec_ready);
endinterface

// File: rtl/conv_sync_fifo.sv
// Synchronous FIFO of pixels with registered read data; rd_data holds between pops.
module conv_sync_fifo
  import conv_decoder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  pixel_t wr_data,
  input  logic   rd_en,
  output pixel_t rd_data,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  pixel_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/conv_decoder_pixel_feeder.sv
// Paces buffered latent pixels onto the decoder link, one frame per frame_go, and flags a dead link.
// Optional zero padding on FIFO underrun is enabled by defining CONV_FEEDER_ZERO_PAD_EN.
module conv_decoder_pixel_feeder
  import conv_decoder_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 784,
  parameter int GAP_CYCLES = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  pixel_t                           wr_data,
  output logic                             full,
  input  logic                             frame_go,
  conv_decoder_pixel_feeder_if.master      link,
  output logic                             busy,
  output logic                             frame_done,
  output logic [$clog2(FRAME_LEN+1)-1:0]   pix_count,
  output logic                             link_err,
`ifdef CONV_FEEDER_ZERO_PAD_EN
  output logic [15:0]                      underrun_cnt,
`endif
  output feeder_state_t                    state_dbg
);
  localparam int CW = $clog2(FRAME_LEN+1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  feeder_state_t state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          fifo_empty, pop, pad, send, start_q, start_d, last;
  pixel_t        fifo_rd_data;

  conv_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign last      = (pix_count == CW'(FRAME_LEN - 1));
  assign send      = pop || pad;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign link.start = start_q;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    pad       = 1'b0;
    case (state)
      IDLE: if (frame_go) state_nxt = SEND;
      SEND: begin
        if (!fifo_empty) pop = 1'b1;
`ifdef CONV_FEEDER_ZERO_PAD_EN
        else pad = 1'b1;
`endif
        if (pop || pad) state_nxt = last ? DONE : ((GAP_CYCLES > 0) ? GAP : SEND);
      end
      GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = SEND;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      pix_count  <= '0;
      start_q    <= 1'b0;
      start_d    <= 1'b0;
      frame_done <= 1'b0;
      link_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_q    <= send;
      start_d    <= start_q;
      frame_done <= (state == DONE);
      // start_d marks the cycle after a strobe, when the decoder must report ready.
      if (start_d && !link.dec_ready) link_err <= 1'b1;
      if (state == IDLE && frame_go) pix_count <= '0;
      else if (send)                 pix_count <= pix_count + 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

`ifdef CONV_FEEDER_ZERO_PAD_EN
  logic zero_sel;
  // A padded strobe shows zero until the next real pop replaces it.
  assign link.input_pixel = zero_sel ? '0 : fifo_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_sel     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (pad)      zero_sel <= 1'b1;
      else if (pop) zero_sel <= 1'b0;
      if (pad && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  assign link.input_pixel = fifo_rd_data;
`endif
endmodule

// File: tb/tb_conv_decoder_pixel_feeder.sv
// Directed bench for conv_decoder_pixel_feeder: vector table for one paced frame plus corner sequences.
module tb_conv_decoder_pixel_feeder;
  import conv_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a: FRAME_LEN=4, GAP=3
  logic          wr_en_a = 1'b0, go_a = 1'b0;
  pixel_t        wr_data_a = '0;
  logic          full_a, busy_a, fd_a, lerr_a;
  logic [2:0]    cnt_a;
  feeder_state_t st_a;
  conv_decoder_pixel_feeder_if link_a();

  // dut_b: FRAME_LEN=20, GAP=0
  logic          wr_en_b = 1'b0, go_b = 1'b0;
  pixel_t        wr_data_b = '0;
  logic          full_b, busy_b, fd_b, lerr_b;
  logic [4:0]    cnt_b;
  feeder_state_t st_b;
  conv_decoder_pixel_feeder_if link_b();

`ifdef CONV_FEEDER_ZERO_PAD_EN
  logic [15:0]   und_a, und_b, und_c;
  logic          wr_en_c = 1'b0, go_c = 1'b0;
  pixel_t        wr_data_c = '0;
  logic          full_c, busy_c, fd_c, lerr_c;
  logic [1:0]    cnt_c;
  feeder_state_t st_c;
  conv_decoder_pixel_feeder_if link_c();

  conv_decoder_pixel_feeder #(.DEPTH(16), .FRAME_LEN(3), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_data(wr_data_c), .full(full_c),
    .frame_go(go_c), .link(link_c), .busy(busy_c), .frame_done(fd_c), .pix_count(cnt_c),
    .link_err(lerr_c), .underrun_cnt(und_c), .state_dbg(st_c));
`endif

  conv_decoder_pixel_feeder #(.DEPTH(16), .FRAME_LEN(4), .GAP_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a),
    .frame_go(go_a), .link(link_a), .busy(busy_a), .frame_done(fd_a), .pix_count(cnt_a),
    .link_err(lerr_a),
`ifdef CONV_FEEDER_ZERO_PAD_EN
    .underrun_cnt(und_a),
`endif
    .state_dbg(st_a));

  conv_decoder_pixel_feeder #(.DEPTH(16), .FRAME_LEN(20), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
    .frame_go(go_b), .link(link_b), .busy(busy_b), .frame_done(fd_b), .pix_count(cnt_b),
    .link_err(lerr_b),
`ifdef CONV_FEEDER_ZERO_PAD_EN
    .underrun_cnt(und_b),
`endif
    .state_dbg(st_b));

  typedef struct {
    logic s;
    int   pix;
    logic b;
    logic fd;
    int   cnt;
  } vec_t;
  vec_t tv[16];

  logic [PIX_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_a(input pixel_t d);
    wr_en_a = 1'b1;
    wr_data_a = d;
    tick();
    wr_en_a = 1'b0;
  endtask

  task automatic push_b(input pixel_t d);
    wr_en_b = 1'b1;
    wr_data_b = d;
    tick();
    wr_en_b = 1'b0;
  endtask

  initial begin
    link_a.dec_ready = 1'b1;
    link_b.dec_ready = 1'b1;
`ifdef CONV_FEEDER_ZERO_PAD_EN
    link_c.dec_ready = 1'b1;
`endif
    // One frame of 4 pixels with 3 idle cycles after each strobe, rows are cycles after frame_go.
    tv[0]  = '{1'b0, 0,       1'b1, 1'b0, 0};
    tv[1]  = '{1'b1, 5,       1'b1, 1'b0, 1};
    tv[2]  = '{1'b0, 5,       1'b1, 1'b0, 1};
    tv[3]  = '{1'b0, 5,       1'b1, 1'b0, 1};
    tv[4]  = '{1'b0, 5,       1'b1, 1'b0, 1};
    tv[5]  = '{1'b1, -7,      1'b1, 1'b0, 2};
    tv[6]  = '{1'b0, -7,      1'b1, 1'b0, 2};
    tv[7]  = '{1'b0, -7,      1'b1, 1'b0, 2};
    tv[8]  = '{1'b0, -7,      1'b1, 1'b0, 2};
    tv[9]  = '{1'b1, 131071,  1'b1, 1'b0, 3};
    tv[10] = '{1'b0, 131071,  1'b1, 1'b0, 3};
    tv[11] = '{1'b0, 131071,  1'b1, 1'b0, 3};
    tv[12] = '{1'b0, 131071,  1'b1, 1'b0, 3};
    tv[13] = '{1'b1, -131072, 1'b1, 1'b0, 4};
    tv[14] = '{1'b0, -131072, 1'b0, 1'b1, 4};
    tv[15] = '{1'b0, -131072, 1'b0, 1'b0, 4};

    do_reset();

    // Reset state and idle behaviour
    chk("rst_start", link_a.start, 0);
    chk("rst_pixel", link_a.input_pixel, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_pix_count", cnt_a, 0);
    chk("rst_link_err", lerr_a, 0);
    chk("rst_full", full_a, 0);
`ifndef CONV_FEEDER_ZERO_PAD_EN
    begin
      logic seen;
      seen = 1'b0;
      go_a = 1'b1;
      tick();
      go_a = 1'b0;
      chk("empty_go_busy", busy_a, 1);
      repeat (8) begin
        tick();
        if (link_a.start) seen = 1'b1;
      end
      chk("empty_go_no_start", seen, 0);
    end
    do_reset();
`endif

    // Paced frame, table driven
    push_a(18'sd5);
    push_a(-18'sd7);
    push_a(18'sd131071);
    push_a(-18'sd131072);
    push_a(18'sd42);
    go_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      go_a = 1'b0;
      chk($sformatf("frame_start_%0d", k), link_a.start, tv[k].s);
      chk($sformatf("frame_pixel_%0d", k), link_a.input_pixel, tv[k].pix);
      chk($sformatf("frame_busy_%0d", k), busy_a, tv[k].b);
      chk($sformatf("frame_done_%0d", k), fd_a, tv[k].fd);
      chk($sformatf("frame_count_%0d", k), cnt_a, tv[k].cnt);
    end
    chk("frame_link_err", lerr_a, 0);
    // Fifth word stays queued for the next frame
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    chk("frame2_count_clear", cnt_a, 0);
    tick();
    chk("frame2_start", link_a.start, 1);
    chk("frame2_pixel", link_a.input_pixel, 42);
    chk("frame2_count", cnt_a, 1);

    // Back-to-back strobes from a full FIFO, push-at-full drop/keep
    for (int i = 0; i < 16; i++) begin
      pixel_t v;
      v = pixel_t'(i * 977 - 9000);
      push_b(v);
      exp_q.push_back(v);
    end
    chk("fill_full", full_b, 1);
    wr_en_b = 1'b1;
    wr_data_b = -18'sd1;
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    chk("drop_full_stays", full_b, 1);
    wr_data_b = 18'sd777;
    exp_q.push_back(18'sd777);
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 0) begin
        wr_en_b = 1'b0;
        chk("keep_full_stays", full_b, 1);
      end
      chk($sformatf("b2b_start_%0d", i), link_b.start, 1);
      chk($sformatf("b2b_pixel_%0d", i), link_b.input_pixel, pixel_t'(exp_q.pop_front()));
    end
    chk("b2b_count", cnt_b, 17);
`ifndef CONV_FEEDER_ZERO_PAD_EN
    tick();
    chk("b2b_stall_start", link_b.start, 0);
    chk("b2b_stall_busy", busy_b, 1);
`endif
    do_reset();

    // Dead link detection, then reset in the middle of a frame
    push_a(18'sd11);
    push_a(18'sd22);
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    tick();
    chk("link_first_start", link_a.start, 1);
    chk("link_err_before", lerr_a, 0);
    link_a.dec_ready = 1'b0;
    tick();
    tick();
    chk("link_err_set", lerr_a, 1);
    link_a.dec_ready = 1'b1;
    tick();
    tick();
    chk("link_second_start", link_a.start, 1);
    chk("link_second_pixel", link_a.input_pixel, 22);
    chk("link_count", cnt_a, 2);
    wr_en_a = 1'b1;
    wr_data_a = 18'sd33;
    tick();
    wr_en_a = 1'b0;
    chk("link_err_sticky", lerr_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_start", link_a.start, 0);
    chk("midrst_pixel", link_a.input_pixel, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_frame_done", fd_a, 0);
    chk("midrst_count", cnt_a, 0);
    chk("midrst_link_err", lerr_a, 0);
    chk("midrst_full", full_a, 0);
    push_a(18'sd44);
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    chk("restart_count", cnt_a, 0);
    chk("restart_busy", busy_a, 1);
    tick();
    chk("restart_start", link_a.start, 1);
    chk("restart_pixel", link_a.input_pixel, 44);
    chk("restart_count1", cnt_a, 1);

`ifdef CONV_FEEDER_ZERO_PAD_EN
    // Zero padding on underrun
    do_reset();
    wr_en_c = 1'b1;
    wr_data_c = 18'sd99;
    tick();
    wr_en_c = 1'b0;
    go_c = 1'b1;
    tick();
    go_c = 1'b0;
    tick();
    chk("pad_start0", link_c.start, 1);
    chk("pad_pixel0", link_c.input_pixel, 99);
    tick();
    chk("pad_start1", link_c.start, 1);
    chk("pad_pixel1", link_c.input_pixel, 0);
    tick();
    chk("pad_start2", link_c.start, 1);
    chk("pad_pixel2", link_c.input_pixel, 0);
    chk("pad_count", cnt_c, 3);
    tick();
    chk("pad_frame_done", fd_c, 1);
    chk("pad_underrun", und_c, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
